// File: rtl/uart_tx.sv
// UART transmitter that drains the TX FIFO: start bit, LSB-first data, optional parity, stop bit(s).
// state    | meaning
// S_IDLE   | line idle high, pops the FIFO as soon as it is non-empty
// S_START  | start bit (low)
// S_DATA   | W data bits, LSB first
// S_PARITY | parity bit, only reachable when PARITY != 0
// S_STOP   | STOP_BITS stop bits (high); may pop the next word in its final cycle
module uart_tx #(
   parameter int W             = 8,
   parameter int CLKS_PER_BAUD = 868,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic         clk,
   input  logic         i_reset,
   input  logic [W-1:0] i_data,
   input  logic         i_empty,
   output logic         o_rd,
   output logic         o_tx,
   output logic         o_busy
);

   localparam int CW = $clog2(CLKS_PER_BAUD);
   localparam int BW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BAUD - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(W - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] baud_cnt;
   logic [BW-1:0] bit_idx;
   logic [W-1:0]  shift_reg;
   logic          par_bit;
   logic          baud_end;
   logic          last_stop;

   assign baud_end  = (baud_cnt == CNT_LAST);
   assign last_stop = (state == S_STOP) && baud_end && (bit_idx == STOP_LAST);

   always_ff @(posedge clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (o_rd) begin
         state_nxt = S_START;
      end else begin
         case (state)
            S_START:  if (baud_end) state_nxt = S_DATA;
            S_DATA:   if (baud_end && bit_idx == DATA_LAST)
                         state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (baud_end) state_nxt = S_STOP;
            S_STOP:   if (last_stop) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_rd   = !i_reset && !i_empty && ((state == S_IDLE) || last_stop);
      o_busy = (state != S_IDLE);
   end

   // Shift register is pre-shifted so shift_reg[0] always holds the next data bit to send.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         o_tx      <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
      end else if (o_rd) begin
         o_tx      <= 1'b0;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= i_data;
         par_bit   <= (PARITY == 1) ? ~^i_data : ^i_data;
      end else if (state != S_IDLE) begin
         baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
         if (baud_end) begin
            case (state)
               S_START: begin
                  o_tx      <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_idx   <= '0;
               end
               S_DATA: begin
                  if (bit_idx == DATA_LAST) begin
                     o_tx    <= (PARITY != 0) ? par_bit : 1'b1;
                     bit_idx <= '0;
                  end else begin
                     o_tx      <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_idx   <= bit_idx + 1'b1;
                  end
               end
               S_PARITY: begin
                  o_tx    <= 1'b1;
                  bit_idx <= '0;
               end
               S_STOP: begin
                  if (bit_idx == STOP_LAST) bit_idx <= '0;
                  else                      bit_idx <= bit_idx + 1'b1;
               end
               default: begin
                  o_tx <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity / odd / even / two stop bits) share one stimulus;
// each lane has a FIFO plus a frame-as-bit-queue model, checked every cycle and pinned by literals.
module tb_uart_tx;

   localparam int CPB = 4;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       armed   = 1'b0;
   int         push_n  = 0;
   logic [7:0] push_d0 = 8'h00;
   logic [7:0] push_d1 = 8'h00;
   logic [7:0] scramble = 8'h5A;

   logic tx_w[4], rd_w[4], busy_w[4], etx_w[4], ebusy_w[4], pend_w[4], empty_w[4];

   int    n_chk = 0;
   int    n_err = 0;
   string lit_name[$];
   int    lit_got[$];
   int    lit_want[$];

   always #5 clk = ~clk;

   always @(posedge clk) scramble <= {scramble[6:0], scramble[7] ^ scramble[5] ^ scramble[4] ^ scramble[3]};

   for (genvar g = 0; g < 4; g++) begin : lane
      localparam int P = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
      localparam int S = (g == 3) ? 2 : 1;

      logic [7:0] fifo[$];
      logic       bits[$];
      logic [7:0] i_data   = 8'h00;
      logic       i_empty  = 1'b1;
      logic       exp_tx   = 1'b1;
      logic       exp_busy = 1'b0;
      logic       pend     = 1'b0;
      logic       o_rd, o_tx, o_busy;

      uart_tx #(.W(8), .CLKS_PER_BAUD(CPB), .PARITY(P), .STOP_BITS(S)) dut (
         .clk     (clk),
         .i_reset (rst),
         .i_data  (i_data),
         .i_empty (i_empty),
         .o_rd    (o_rd),
         .o_tx    (o_tx),
         .o_busy  (o_busy)
      );

      assign tx_w[g]    = o_tx;
      assign rd_w[g]    = o_rd;
      assign busy_w[g]  = o_busy;
      assign etx_w[g]   = exp_tx;
      assign ebusy_w[g] = exp_busy;
      assign pend_w[g]  = pend;
      assign empty_w[g] = i_empty;

      // A popped word becomes its whole frame, one queue entry per clock cycle on the line.
      always @(posedge clk) begin
         if (rst) begin
            bits.delete();
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
         end else if (fifo.size() != 0 && bits.size() == 0) begin
            for (int k = 0; k < CPB; k++) bits.push_back(1'b0);
            for (int b = 0; b < 8; b++)
               for (int k = 0; k < CPB; k++) bits.push_back(fifo[0][b]);
            if (P != 0)
               for (int k = 0; k < CPB; k++)
                  bits.push_back(($countones(fifo[0]) % 2 == 1) == (P == 2));
            for (int k = 0; k < S * CPB; k++) bits.push_back(1'b1);
            void'(fifo.pop_front());
            exp_tx   <= bits.pop_front();
            exp_busy <= 1'b1;
         end else if (bits.size() != 0) begin
            exp_tx   <= bits.pop_front();
            exp_busy <= 1'b1;
         end else begin
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
         end
         if (push_n > 0) fifo.push_back(push_d0);
         if (push_n > 1) fifo.push_back(push_d1);
         pend    <= (bits.size() != 0);
         i_empty <= (fifo.size() == 0);
         i_data  <= (fifo.size() == 0) ? scramble : fifo[0];
      end
   end

   function automatic int lane_errs();
      int e = 0;
      for (int g = 0; g < 4; g++) begin
         logic want_rd;
         want_rd = !rst && !empty_w[g] && !pend_w[g];
         if (tx_w[g] !== etx_w[g]) begin
            e++;
            $display("FAIL lane%0d o_tx at %0t: got %b want %b", g, $time, tx_w[g], etx_w[g]);
         end
         if (busy_w[g] !== ebusy_w[g]) begin
            e++;
            $display("FAIL lane%0d o_busy at %0t: got %b want %b", g, $time, busy_w[g], ebusy_w[g]);
         end
         if (rd_w[g] !== want_rd) begin
            e++;
            $display("FAIL lane%0d o_rd at %0t: got %b want %b", g, $time, rd_w[g], want_rd);
         end
      end
      return e;
   endfunction

   function automatic int lit_errs();
      int e = 0;
      while (lit_name.size() != 0) begin
         if (lit_got[0] != lit_want[0]) begin
            e++;
            $display("FAIL %s: got %0d want %0d", lit_name[0], lit_got[0], lit_want[0]);
         end
         void'(lit_name.pop_front());
         void'(lit_got.pop_front());
         void'(lit_want.pop_front());
      end
      return e;
   endfunction

   always @(negedge clk) begin
      n_chk <= n_chk + (armed ? 12 : 0) + lit_name.size();
      n_err <= n_err + (armed ? lane_errs() : 0) + lit_errs();
   end

   task automatic lit(input string name, input int got, input int want);
      lit_name.push_back(name);
      lit_got.push_back(got);
      lit_want.push_back(want);
   endtask

   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_words(input int n, input logic [7:0] d0, input logic [7:0] d1);
      @(posedge clk);
      #1;
      push_n  = n;
      push_d0 = d0;
      push_d1 = d1;
      @(posedge clk);
      #1;
      push_n  = 0;
   endtask

   task automatic wait_rd(input int l, output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (rd_w[l]) found = 1'b1;
      end
      if (!found) lit("o_rd timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         found;
      int         gap, lows, rdc, ones;
      logic       tx40, busy44;
      logic [9:0] pat;

      pat = 10'b10_1010_1010;
      repeat (2) @(posedge clk);
      #1;
      armed = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      skip(5);

      push_words(1, 8'h55, 8'h00);
      wait_rd(0, found);
      if (found) begin
         skip(2);
         lit("single bit0", int'(tx_w[0]), int'(pat[0]));
         for (int k = 1; k < 10; k++) begin
            skip(4);
            lit($sformatf("single bit%0d", k), int'(tx_w[0]), int'(pat[k]));
         end
         skip(2);
         lit("single busy last", int'(busy_w[0]), 1);
         skip(1);
         lit("single busy after", int'(busy_w[0]), 0);
         lit("single tx after", int'(tx_w[0]), 1);
      end
      skip(60);

      push_words(2, 8'hA3, 8'h0F);
      wait_rd(0, found);
      if (found) begin
         gap  = 0;
         tx40 = 1'b0;
         for (int i = 1; i <= 60 && gap == 0; i++) begin
            @(negedge clk);
            if (i == 40) tx40 = tx_w[0];
            if (rd_w[0]) gap = i;
         end
         lit("b2b pop spacing", gap, 40);
         lit("b2b last stop", int'(tx40), 1);
         skip(1);
         lit("b2b second start", int'(tx_w[0]), 0);
      end
      skip(100);

      push_words(1, 8'h07, 8'h00);
      wait_rd(2, found);
      if (found) begin
         skip(38);
         lit("even parity bit", int'(tx_w[2]), 1);
         lit("odd parity bit", int'(tx_w[1]), 0);
      end
      skip(60);

      push_words(1, 8'hFF, 8'h00);
      wait_rd(3, found);
      if (found) begin
         lows   = 0;
         busy44 = 1'b0;
         for (int i = 1; i <= 44; i++) begin
            @(negedge clk);
            if (!tx_w[3]) lows++;
            if (i == 44) busy44 = busy_w[3];
         end
         lit("stop2 low cycles", lows, 4);
         lit("stop2 busy last", int'(busy44), 1);
         skip(1);
         lit("stop2 busy after", int'(busy_w[3]), 0);
      end
      skip(60);

      push_words(2, 8'h55, 8'h3C);
      wait_rd(0, found);
      if (found) begin
         skip(13);
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         lit("reset tx", int'(tx_w[0]), 1);
         lit("reset busy", int'(busy_w[0]), 0);
         lit("repop after reset", int'(rd_w[0]), 1);
      end
      skip(60);

      rdc  = 0;
      ones = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd_w[0] || rd_w[1] || rd_w[2] || rd_w[3]) rdc++;
         if (tx_w[0] && tx_w[1] && tx_w[2] && tx_w[3]) ones++;
      end
      lit("empty hold o_rd", rdc, 0);
      lit("empty hold tx high", ones, 100);

      repeat (3) @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
